// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and helpers; decode and EX use the same values.
package if_stage_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
    localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_REDIR,
        PC_EXC
    } pc_sel_e;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC for decode.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic            fetch_exc_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;
    logic            fexc_q, fexc_d;
    logic            misaligned;

    assign misaligned = pc_misaligned(pc_i);

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        fexc_d     = fexc_q;
        // Flush wins over stall: a stalled IF/ID entry is wrong-path once we redirect.
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            fexc_d  = 1'b0;
        end else if (!stall_i) begin
            instr_d    = misaligned ? NOP_INSTR : instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
            fexc_d     = misaligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            fexc_q     <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            fexc_q     <= fexc_d;
        end
    end

    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4_q;
    assign valid_o     = valid_q;
    assign fetch_exc_o = fexc_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_redirect,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] D_instruction,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc_plus4,
    output logic        D_valid,
    output logic        D_fetch_exc
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    pc_sel_e         pc_sel;

    assign pc_plus4 = pc_q + 32'd4;  // wraps 32'hFFFF_FFFC -> 0

    always_comb begin
        pc_sel = PC_SEQ;
        if (exc_redirect)  pc_sel = PC_EXC;
        else if (redirect) pc_sel = PC_REDIR;
        else if (stall)    pc_sel = PC_HOLD;
    end

    always_comb begin
        pc_d = pc_plus4;
        unique case (pc_sel)
            PC_EXC:   pc_d = EXC_VECTOR;
            PC_REDIR: pc_d = redirect_pc;
            PC_HOLD:  pc_d = pc_q;
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) pc_q <= RESET_PC;
        else           pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i       (SYS_clk),
        .reset_i     (SYS_reset),
        .stall_i     (stall),
        .flush_i     (exc_redirect | redirect),
        .pc_i        (pc_q),
        .pc_plus4_i  (pc_plus4),
        .instr_i     (imem_rdata),
        .instr_o     (D_instruction),
        .pc_o        (D_pc),
        .pc_plus4_o  (D_pc_plus4),
        .valid_o     (D_valid),
        .fetch_exc_o (D_fetch_exc)
    );

endmodule

// File: tb/tb_if_stage.sv
// Table-driven check of if_stage with a scoreboard queue of hand-derived expectations.
module tb_if_stage;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset, stall, redirect, exc_redirect;
    logic [31:0] redirect_pc, imem_addr, imem_rdata;
    logic [31:0] D_instruction, D_pc, D_pc_plus4;
    logic        D_valid, D_fetch_exc;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .SYS_clk       (SYS_clk),
        .SYS_reset     (SYS_reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .exc_redirect  (exc_redirect),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .D_instruction (D_instruction),
        .D_pc          (D_pc),
        .D_pc_plus4    (D_pc_plus4),
        .D_valid       (D_valid),
        .D_fetch_exc   (D_fetch_exc)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Instruction memory: each word is distinct and derived from its address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction
    assign imem_rdata = w(imem_addr);

    typedef struct packed {
        logic        rst, stl, red, exc;
        logic [31:0] rpc;
        logic [31:0] addr, pc, pc4, instr;
        logic        valid, fexc;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr, pc, pc4, instr;
        logic        valid, fexc;
    } exp_t;

    function automatic vec_t mk(input logic rst, input logic stl, input logic red,
                                input logic exc, input logic [31:0] rpc,
                                input logic [31:0] addr, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic [31:0] instr,
                                input logic valid, input logic fexc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.red = red; v.exc = exc; v.rpc = rpc;
        v.addr = addr; v.pc = pc; v.pc4 = pc4; v.instr = instr;
        v.valid = valid; v.fexc = fexc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[18];
    exp_t sb[$];

    initial begin
        exp_t e;
        logic [31:0] addr_before;
        logic        valid_before;

        //           rst stl red exc rpc           addr          pc            pc4           instr          v  fx
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0,         0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         32'h4,        32'h0,        32'h4,        w(32'h0),      1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         32'h8,        32'h4,        32'h8,        w(32'h4),      1, 0);
        vecs[3]  = mk(0, 1, 0, 0, 32'h0,         32'h8,        32'h4,        32'h8,        w(32'h4),      1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,         32'h8,        32'h4,        32'h8,        w(32'h4),      1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         32'hC,        32'h8,        32'hC,        w(32'h8),      1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         32'h10,       32'hC,        32'h10,       w(32'hC),      1, 0);
        vecs[7]  = mk(0, 1, 1, 0, 32'h40,        32'h40,       32'hC,        32'h10,       32'h0,         0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         32'h44,       32'h40,       32'h44,       w(32'h40),     1, 0);
        vecs[9]  = mk(0, 0, 1, 1, 32'h40,        32'h8000_0180,32'h40,       32'h44,       32'h0,         0, 0);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,         32'h8000_0184,32'h8000_0180,32'h8000_0184,w(32'h8000_0180),1, 0);
        vecs[11] = mk(0, 0, 1, 0, 32'h42,        32'h42,       32'h8000_0180,32'h8000_0184,32'h0,         0, 0);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,         32'h46,       32'h42,       32'h46,       32'h0,         1, 1);
        vecs[13] = mk(1, 1, 1, 0, 32'h40,        32'h0,        32'h0,        32'h0,        32'h0,         0, 0);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,         32'h4,        32'h0,        32'h4,        w(32'h0),      1, 0);
        vecs[15] = mk(0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,32'h0,        32'h4,        32'h0,         0, 0);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         32'h0,        32'hFFFF_FFFC,32'h0,        w(32'hFFFF_FFFC),1, 0);
        vecs[17] = mk(0, 1, 0, 1, 32'h0,         32'h8000_0180,32'hFFFF_FFFC,32'h0,        32'h0,         0, 0);

        SYS_reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        exc_redirect = 1'b0; redirect_pc = '0;

        for (int i = 0; i < 18; i++) begin
            @(negedge SYS_clk);
            SYS_reset    = vecs[i].rst;
            stall        = vecs[i].stl;
            redirect     = vecs[i].red;
            exc_redirect = vecs[i].exc;
            redirect_pc  = vecs[i].rpc;
            sb.push_back('{addr: vecs[i].addr, pc: vecs[i].pc, pc4: vecs[i].pc4,
                           instr: vecs[i].instr, valid: vecs[i].valid, fexc: vecs[i].fexc});
            @(posedge SYS_clk);
            #1;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty vec=%0d", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d imem_addr", i),   imem_addr,            e.addr);
                check($sformatf("v%0d D_pc", i),        D_pc,                 e.pc);
                check($sformatf("v%0d D_pc_plus4", i),  D_pc_plus4,           e.pc4);
                check($sformatf("v%0d D_instr", i),     D_instruction,        e.instr);
                check($sformatf("v%0d D_valid", i),     {31'b0, D_valid},     {31'b0, e.valid});
                check($sformatf("v%0d D_fetch_exc", i), {31'b0, D_fetch_exc}, {31'b0, e.fexc});
            end
        end

        // Mid-cycle input changes must not reach the outputs before the next edge.
        @(negedge SYS_clk);
        addr_before  = imem_addr;
        valid_before = D_valid;
        SYS_reset = 1'b0; stall = 1'b0;
        redirect = 1'b1; exc_redirect = 1'b1; redirect_pc = 32'h1234_5678;
        #1;
        check("comb_path imem_addr", imem_addr, 32'h8000_0180);
        check("comb_path D_valid", {31'b0, D_valid}, {31'b0, valid_before});
        check("comb_path addr_stable", imem_addr, addr_before);
        redirect = 1'b0; exc_redirect = 1'b0;
        @(posedge SYS_clk);
        #1;
        check("after_exc_vec imem_addr", imem_addr, 32'h8000_0184);
        check("after_exc_vec D_pc", D_pc, 32'h8000_0180);
        check("after_exc_vec D_instr", D_instruction, w(32'h8000_0180));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
